shift_cmd_sequencer: RTL



---
 rtl/shift_reg_pkg.sv | 22 ++
 rtl/cmd_fifo.sv | 54 +++++
 rtl/shift_cmd_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift register command path.
// Mode codes, sequencer states and command entry sizing.
package shift_reg_pkg;

  localparam int MODE_W = 2;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  // Entry is {mode, data, count}, count in the LSBs.
  function automatic int cmd_w(int width, int cnt_w);
    return MODE_W + width + cnt_w;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for queued commands.
// Wrap-bit pointers; flush empties it in one edge.
module cmd_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign level = wptr - rptr;

  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command sequencer for the 4-bit universal shift register.
// Plays queued {mode, data, count} commands, then holds.
module shift_cmd_sequencer
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_data,
  output logic             busy,
  output logic             done
);

  localparam int E  = cmd_w(WIDTH, CNT_W);
  localparam int AW = $clog2(DEPTH);

  logic [E-1:0]     head;
  logic [E-1:0]     entry;
  logic             full;
  logic             empty;
  logic [AW:0]      level;
  logic [AW:0]      occ_n;
  logic             push;
  logic             pop;
  logic             load;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [1:0]       mode_n;
  logic [WIDTH-1:0] data_n;
  logic             busy_n;
  logic             done_n;

  assign entry     = {cmd_mode, cmd_data, cmd_count};
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full && !flush;

  cmd_fifo #(
    .W     (E),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mode_n  = sr_mode;
    data_n  = sr_data;
    load    = 1'b0;
    pop     = 1'b0;
    if (flush) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      mode_n  = MODE_HOLD;
    end else begin
      unique case (state)
        ST_IDLE: begin
          mode_n = MODE_HOLD;
          load   = !empty;
        end
        ST_RUN: begin
          if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            state_n = ST_IDLE;
            mode_n  = MODE_HOLD;
          end
        end
      endcase
      if (load) begin
        pop     = 1'b1;
        state_n = ST_RUN;
        mode_n  = head[E-1 -: MODE_W];
        data_n  = head[CNT_W +: WIDTH];
        cnt_n   = head[CNT_W-1:0];
      end
    end
  end

  // Occupancy after this edge decides busy for the next cycle.
  always_comb begin
    occ_n  = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    busy_n = !flush && ((state_n == ST_RUN) || (occ_n != '0));
    done_n = !flush && (state_n == ST_RUN) && (cnt_n == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sr_mode <= MODE_HOLD;
      sr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sr_mode <= mode_n;
      sr_data <= data_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule
